ram_2x8_ctrl: RTL

- Request/response front-end controller directly upstream of the 2-word x 8-bit RAM (RAM_2x8).
- Accepts single-beat read/write requests over a valid/ready handshake and sequences the RAM's addr / r_w / data pins.
- Captures read data and returns it over a response handshake.
- After reset, optionally zero-fills both RAM words before the first request is accepted.

---
 rtl/ram_2x8_ctrl_if.sv | 25 ++
 rtl/ram_2x8_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/ram_2x8_ctrl_if.sv
// ram_2x8_ctrl_if: request/response handshake bundle for the RAM_2x8 front-end.
//   req_valid/req_ready/req_we/req_addr/req_wdata : single-beat request channel
//   rsp_valid/rsp_ready/rsp_data/rsp_err          : response channel
//   master = request source / response sink, slave = controller
interface ram_2x8_ctrl_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_we;
  logic       req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/ram_2x8_ctrl.sv
// ram_2x8_ctrl: valid/ready front-end for the 2-word x 8-bit RAM (RAM_2x8).
// Sequences the RAM addr/r_w/data pins for single-beat reads and writes,
// captures read data into a response, and optionally zero-fills both words
// after reset.
// Ports:
//   clk        system clock, rising edge
//   clear      asynchronous active-low reset
//   bus        request/response handshake (slave side)
//   ram_addr   RAM word address
//   ram_r_w    RAM write strobe (1 = write)
//   ram_in     RAM write data (bit 7 = in1)
//   ram_out    RAM read data (bit 7 = out1)
//   init_done  zero-fill sequence complete
// Parameters: READ_LAT (1..3) read hold cycles, INIT_ZERO (1 = zero-fill).
// Optional build macro RAM_CTRL_VERIFY_EN: read back every write and flag
// a mismatch on rsp_err; without it rsp_err stays 0.
// All outputs are registered; the next-state logic computes the value each
// output register takes at the coming edge.
module ram_2x8_ctrl #(
  parameter int unsigned READ_LAT  = 1,
  parameter int unsigned INIT_ZERO = 1
) (
  input  logic                 clk,
  input  logic                 clear,
  ram_2x8_ctrl_if.slave        bus,
  output logic                 ram_addr,
  output logic                 ram_r_w,
  output logic [7:0]           ram_in,
  input  logic [7:0]           ram_out,
  output logic                 init_done
);

  localparam int unsigned CNT_W = 2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(READ_LAT - 1);

  typedef enum logic [2:0] {
    S_INIT0,
    S_INIT1,
    S_IDLE,
    S_WR,
    S_RD,
    S_RSP
`ifdef RAM_CTRL_VERIFY_EN
    , S_VFY
`endif
  } state_t;

  localparam state_t S_RESET = (INIT_ZERO != 0) ? S_INIT0 : S_IDLE;

  state_t           r_state,     w_state_nxt;
  logic [CNT_W-1:0] r_cnt,       w_cnt_nxt;
  logic             r_req_ready, w_req_ready_nxt;
  logic             r_rsp_valid, w_rsp_valid_nxt;
  logic [7:0]       r_rsp_data,  w_rsp_data_nxt;
  logic             r_rsp_err,   w_rsp_err_nxt;
  logic             r_ram_addr,  w_ram_addr_nxt;
  logic             r_ram_r_w,   w_ram_r_w_nxt;
  logic [7:0]       r_ram_in,    w_ram_in_nxt;
  logic             r_init_done, w_init_done_nxt;
  logic             w_cnt_last;

  assign w_cnt_last = (r_cnt == CNT_LAST);

  // State and output registers
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      r_state     <= S_RESET;
      r_cnt       <= '0;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 8'h00;
      r_rsp_err   <= 1'b0;
      r_ram_addr  <= 1'b0;
      r_ram_r_w   <= 1'b0;
      r_ram_in    <= 8'h00;
      r_init_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_req_ready <= w_req_ready_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_data  <= w_rsp_data_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      r_ram_addr  <= w_ram_addr_nxt;
      r_ram_r_w   <= w_ram_r_w_nxt;
      r_ram_in    <= w_ram_in_nxt;
      r_init_done <= w_init_done_nxt;
    end
  end

  // Next state and next output values
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_req_ready_nxt = r_req_ready;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_data_nxt  = r_rsp_data;
    w_rsp_err_nxt   = r_rsp_err;
    w_ram_addr_nxt  = r_ram_addr;
    w_ram_r_w_nxt   = 1'b0;          // strobe only ever asserted for one cycle per step
    w_ram_in_nxt    = r_ram_in;
    w_init_done_nxt = r_init_done;

    unique case (r_state)
      S_INIT0: begin
        w_ram_r_w_nxt  = 1'b1;
        w_ram_addr_nxt = 1'b0;
        w_ram_in_nxt   = 8'h00;
        w_state_nxt    = S_INIT1;
      end
      S_INIT1: begin
        w_ram_r_w_nxt  = 1'b1;
        w_ram_addr_nxt = 1'b1;
        w_ram_in_nxt   = 8'h00;
        w_state_nxt    = S_IDLE;
      end
      S_IDLE: begin
        w_init_done_nxt = 1'b1;
        if (bus.req_valid && r_req_ready) begin
          // ram_addr/ram_in double as the latched request address and data
          w_req_ready_nxt = 1'b0;
          w_ram_addr_nxt  = bus.req_addr;
          w_ram_in_nxt    = bus.req_wdata;
          w_cnt_nxt       = '0;
          if (bus.req_we) begin
            w_ram_r_w_nxt = 1'b1;
            w_state_nxt   = S_WR;
          end else begin
            w_state_nxt   = S_RD;
          end
        end else begin
          w_req_ready_nxt = 1'b1;
        end
      end
      S_WR: begin
`ifdef RAM_CTRL_VERIFY_EN
        w_cnt_nxt       = '0;
        w_state_nxt     = S_VFY;
`else
        w_rsp_data_nxt  = r_ram_in;
        w_rsp_err_nxt   = 1'b0;
        w_rsp_valid_nxt = 1'b1;
        w_state_nxt     = S_RSP;
`endif
      end
      S_RD: begin
        if (w_cnt_last) begin
          w_rsp_data_nxt  = ram_out;
          w_rsp_err_nxt   = 1'b0;
          w_rsp_valid_nxt = 1'b1;
          w_state_nxt     = S_RSP;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
`ifdef RAM_CTRL_VERIFY_EN
      S_VFY: begin
        if (w_cnt_last) begin
          w_rsp_data_nxt  = r_ram_in;
          w_rsp_err_nxt   = (ram_out != r_ram_in);
          w_rsp_valid_nxt = 1'b1;
          w_state_nxt     = S_RSP;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
`endif
      S_RSP: begin
        // Reopen req_ready on the closing edge so the next request can
        // be accepted on the following edge.
        if (bus.rsp_ready) begin
          w_rsp_valid_nxt = 1'b0;
          w_req_ready_nxt = 1'b1;
          w_state_nxt     = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.req_ready = r_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_err   = r_rsp_err;
  assign ram_addr      = r_ram_addr;
  assign ram_r_w       = r_ram_r_w;
  assign ram_in        = r_ram_in;
  assign init_done     = r_init_done;

endmodule
